// File: rtl/axi_master_initiator.sv
// axi_master_initiator: single-outstanding AXI master that sequences
// AW/W/B or AR/R bursts from a command port and reports one status word.
module axi_master_initiator #(
  parameter int ID_W           = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ID_W-1:0]     cmd_id,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [3:0]          cmd_len,
  input  logic [2:0]          cmd_size,
  input  logic [1:0]          cmd_burst,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                done_valid,
  output logic [1:0]          done_resp,
  output logic [2:0]          done_err,
  output logic [ID_W-1:0]     AWID,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [3:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [ID_W-1:0]     BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [ID_W-1:0]     ARID,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [3:0]          ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [ID_W-1:0]     RID,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TL = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TW-1:0] TLIM = TW'(TL);
  localparam bit TEN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [2:0] {
    IDLE, AW_ADDR, W_DATA, B_RESP, AR_ADDR, R_DATA, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic [3:0]          beat_q, beat_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [1:0]          resp_q, resp_d;
  logic [2:0]          err_q, err_d;

  logic last_beat;
  logic expire;

  assign last_beat = (beat_q == len_q);
  assign expire    = TEN && (tmo_q == TLIM);

  assign AWID    = id_q;
  assign AWADDR  = addr_q;
  assign AWLEN   = len_q;
  assign AWSIZE  = size_q;
  assign AWBURST = burst_q;
  assign ARID    = id_q;
  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARSIZE  = size_q;
  assign ARBURST = burst_q;

  assign WDATA   = wr_data;
  assign WSTRB   = wr_strb;
  assign rd_data = RDATA;
  assign rd_last = RLAST;

  assign done_resp = resp_q;
  assign done_err  = err_q;

  // next-state, channel handshakes and status accumulation
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    tmo_d      = '0;
    resp_d     = resp_q;
    err_d      = err_q;
    cmd_ready  = 1'b0;
    AWVALID    = 1'b0;
    WVALID     = 1'b0;
    WLAST      = 1'b0;
    wr_ready   = 1'b0;
    BREADY     = 1'b0;
    ARVALID    = 1'b0;
    RREADY     = 1'b0;
    rd_valid   = 1'b0;
    done_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          id_d    = cmd_id;
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          size_d  = cmd_size;
          burst_d = cmd_burst;
          beat_d  = '0;
          resp_d  = '0;
          err_d   = '0;
          state_d = cmd_write ? AW_ADDR : AR_ADDR;
        end
      end
      AW_ADDR: begin
        AWVALID = 1'b1;
        if (AWREADY) state_d = W_DATA;
      end
      W_DATA: begin
        WVALID   = wr_valid;
        wr_ready = WREADY;
        WLAST    = last_beat;
        if (wr_valid && WREADY) begin
          beat_d = beat_q + 4'd1;
          if (last_beat) state_d = B_RESP;
        end
      end
      B_RESP: begin
        BREADY = !expire;
        if (expire) begin
          err_d[2] = 1'b1;
          state_d  = DONE;
        end else if (BVALID) begin
          resp_d   = BRESP;
          err_d[0] = (BID != id_q);
          state_d  = DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      AR_ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_d = R_DATA;
      end
      R_DATA: begin
        RREADY   = rd_ready && !expire;
        rd_valid = RVALID && !expire;
        if (expire) begin
          err_d[2] = 1'b1;
          state_d  = DONE;
        end else if (RVALID && rd_ready) begin
          beat_d   = beat_q + 4'd1;
          resp_d   = (RRESP > resp_q) ? RRESP : resp_q;
          err_d[0] = err_q[0] | (RID != id_q);
          if (RLAST || last_beat) begin
            err_d[1] = (RLAST != last_beat);
            state_d  = DONE;
          end
        end else if (!RVALID) begin
          tmo_d = tmo_q + TW'(1);
        end else begin
          tmo_d = tmo_q;
        end
      end
      DONE: begin
        done_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and payload registers, synchronous reset aborts any transfer
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
      resp_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_master_initiator.sv
// tb_axi_master_initiator: directed bursts against a small AXI slave
// model, with queue-based monitors checking every handshake and status.
module tb_axi_master_initiator;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_id, cmd_len;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic [31:0] wr_data, rd_data;
  logic [3:0]  wr_strb;
  logic        wr_valid, wr_ready, rd_last, rd_valid, rd_ready;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic [2:0]  done_err;
  logic [3:0]  AWID, AWLEN, ARID, ARLEN, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY;
  logic        BVALID, BREADY, ARVALID, ARREADY;
  logic        RLAST, RVALID, RREADY;
  logic [3:0]  WSTRB;

  always #5 ACLK = ~ACLK;

  axi_master_initiator #(
    .ID_W(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct packed {
    logic [3:0] id; logic [31:0] addr; logic [3:0] len;
  } ax_t;
  typedef struct packed {
    logic [31:0] data; logic [3:0] strb; logic last;
  } w_t;
  typedef struct packed { logic [31:0] data; logic last; } rd_t;
  typedef struct packed {
    logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;
  } r_t;
  typedef struct packed { logic [1:0] resp; logic [2:0] err; } dn_t;

  ax_t exp_aw[$], exp_ar[$];
  w_t  exp_w[$], wq[$];
  rd_t exp_rd[$];
  r_t  rq[$];
  dn_t exp_dn[$];

  int tests = 0;
  int errs = 0;
  int w_seen = 0;
  int aw_delay = 0;
  logic b_en = 1'b1;
  logic [3:0] b_id = '0;
  logic [1:0] b_resp = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitors: every observed handshake pops and checks the head of its queue
  always @(negedge ACLK) begin : mon
    ax_t a;
    w_t w;
    rd_t r;
    dn_t d;
    if (AWVALID && AWREADY) begin
      if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
      else begin
        a = exp_aw.pop_front();
        chk("aw_id", AWID, a.id);
        chk("aw_addr", AWADDR, a.addr);
        chk("aw_len", AWLEN, a.len);
        chk("aw_size_burst", {AWSIZE, AWBURST}, {3'd2, 2'd1});
      end
    end
    if (ARVALID && ARREADY) begin
      if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
      else begin
        a = exp_ar.pop_front();
        chk("ar_id", ARID, a.id);
        chk("ar_addr", ARADDR, a.addr);
        chk("ar_len", ARLEN, a.len);
        chk("ar_size_burst", {ARSIZE, ARBURST}, {3'd2, 2'd1});
      end
    end
    if (WVALID && WREADY) begin
      w_seen++;
      if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
      else begin
        w = exp_w.pop_front();
        chk("w_data", WDATA, w.data);
        chk("w_strb", WSTRB, w.strb);
        chk("w_last", WLAST, w.last);
      end
    end
    if (rd_valid && rd_ready) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        r = exp_rd.pop_front();
        chk("rd_data", rd_data, r.data);
        chk("rd_last", rd_last, r.last);
      end
    end
    if (done_valid) begin
      if (exp_dn.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        d = exp_dn.pop_front();
        chk("done_resp", done_resp, d.resp);
        chk("done_err", done_err, d.err);
      end
    end
  end

  // slave model plus write-data source, driven just after each edge
  initial begin : slave
    logic rst_s, ar_hs, r_hs, w_hs, r_active;
    int aw_cnt;
    r_t r;
    w_t w;
    AWREADY = 0; WREADY = 1; BVALID = 0; BID = 0; BRESP = 0;
    ARREADY = 0; RVALID = 0; RID = 0; RDATA = 0; RRESP = 0; RLAST = 0;
    wr_valid = 0; wr_data = 0; wr_strb = 0;
    r_active = 0; aw_cnt = 0;
    forever begin
      @(negedge ACLK);
      rst_s = ARESET;
      ar_hs = ARVALID && ARREADY;
      r_hs  = RVALID && RREADY;
      w_hs  = wr_valid && wr_ready;
      @(posedge ACLK);
      #2;
      if (rst_s) begin
        AWREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
        wr_valid = 0; r_active = 0; aw_cnt = 0;
        wq.delete();
        rq.delete();
      end else begin
        if (AWVALID) begin
          AWREADY = (aw_cnt >= aw_delay);
          aw_cnt++;
        end else begin
          AWREADY = 0;
          aw_cnt = 0;
        end
        ARREADY = ARVALID;
        BVALID = b_en && BREADY;
        BID = b_id;
        BRESP = b_resp;
        if (ar_hs) r_active = 1;
        if (done_valid) r_active = 0;
        if (RVALID && !r_hs) begin
        end else if (r_active && rq.size() > 0) begin
          r = rq.pop_front();
          RVALID = 1; RID = r.id; RDATA = r.data;
          RRESP = r.resp; RLAST = r.last;
        end else begin
          RVALID = 0;
        end
        if (wr_valid && !w_hs) begin
        end else if (wq.size() > 0) begin
          w = wq.pop_front();
          wr_valid = 1; wr_data = w.data; wr_strb = w.strb;
        end else begin
          wr_valid = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [3:0] id,
                          input logic [31:0] addr, input logic [3:0] len);
    int n;
    n = 0;
    cmd_valid = 1; cmd_write = wr; cmd_id = id; cmd_addr = addr;
    cmd_len = len; cmd_size = 3'd2; cmd_burst = 2'd1;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("cmd_wait_timeout", 0, 1);
    tick();
    cmd_valid = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_dn.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk("done_pending", exp_dn.size(), 0);
  endtask

  task automatic push_w(input logic [31:0] base, input int len, input int nexp);
    w_t w;
    for (int i = 0; i <= len; i++) begin
      w.data = base + 32'(i);
      w.strb = 4'(15 - i);
      w.last = (i == len);
      wq.push_back(w);
      if (i < nexp) exp_w.push_back(w);
    end
  endtask

  task automatic push_r(input logic [3:0] id, input logic [31:0] d,
                        input logic [1:0] rs, input logic l);
    r_t r;
    rd_t e;
    r.id = id; r.data = d; r.resp = rs; r.last = l;
    e.data = d; e.last = l;
    rq.push_back(r);
    exp_rd.push_back(e);
  endtask

  task automatic push_ax(input logic wr, input logic [3:0] id,
                         input logic [31:0] addr, input logic [3:0] len);
    ax_t a;
    a.id = id; a.addr = addr; a.len = len;
    if (wr) exp_aw.push_back(a);
    else exp_ar.push_back(a);
  endtask

  task automatic push_dn(input logic [1:0] rs, input logic [2:0] er);
    dn_t d;
    d.resp = rs; d.err = er;
    exp_dn.push_back(d);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    ARESET = 1; cmd_valid = 0; cmd_write = 0; cmd_id = 0; cmd_addr = 0;
    cmd_len = 0; cmd_size = 0; cmd_burst = 0; rd_ready = 1;
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_valids", {AWVALID, ARVALID, WVALID, BREADY, RREADY}, 0);
    chk("rst_streams", {rd_valid, wr_ready, done_valid}, 0);
    chk("rst_payload", {AWADDR, AWLEN, AWID}, 0);
    ARESET = 0;
    repeat (2) tick();

    // 4-beat write, slave always ready
    b_id = 4'd2; b_resp = 2'd0;
    push_w(32'h1000_0000, 3, 4);
    push_ax(1, 4'd2, 32'h5000_0000, 4'd3);
    push_dn(2'd0, 3'b000);
    send_cmd(1, 4'd2, 32'h5000_0000, 4'd3);
    chk("aw_rise", AWVALID, 1);
    chk("cmd_busy", cmd_ready, 0);
    wait_done();
    chk("cmd_ready_after_wr", cmd_ready, 1);
    chk("w_drained", exp_w.size(), 0);

    // 8-beat read, clean
    for (int i = 0; i < 8; i++)
      push_r(4'd5, 32'hA000_0000 + 32'(i), 2'd0, i == 7);
    push_ax(0, 4'd5, 32'h6000_0000, 4'd7);
    push_dn(2'd0, 3'b000);
    send_cmd(0, 4'd5, 32'h6000_0000, 4'd7);
    chk("ar_rise", ARVALID, 1);
    wait_done();
    chk("rd_drained", exp_rd.size(), 0);

    // write with AWREADY held low for 5 cycles
    aw_delay = 5; b_id = 4'd1;
    push_w(32'h2000_0000, 0, 1);
    push_ax(1, 4'd1, 32'h5000_0100, 4'd0);
    push_dn(2'd0, 3'b000);
    send_cmd(1, 4'd1, 32'h5000_0100, 4'd0);
    n = 0;
    while (AWVALID && n < 20) begin
      chk("aw_addr_stable", AWADDR, 32'h5000_0100);
      tick();
      n++;
    end
    chk("aw_valid_cycles", n, 6);
    aw_delay = 0;
    wait_done();

    // read with SLVERR on beat 2 and wrong RID on beat 3
    push_r(4'd5, 32'hB000_0000, 2'd0, 0);
    push_r(4'd5, 32'hB000_0001, 2'd2, 0);
    push_r(4'd4, 32'hB000_0002, 2'd0, 0);
    push_r(4'd5, 32'hB000_0003, 2'd0, 1);
    push_ax(0, 4'd5, 32'h6000_0100, 4'd3);
    push_dn(2'd2, 3'b001);
    send_cmd(0, 4'd5, 32'h6000_0100, 4'd3);
    wait_done();

    // read where the slave ends early with RLAST on beat 2
    push_r(4'd5, 32'hC000_0000, 2'd0, 0);
    push_r(4'd5, 32'hC000_0001, 2'd0, 1);
    push_ax(0, 4'd5, 32'h6000_0200, 4'd3);
    push_dn(2'd0, 3'b010);
    send_cmd(0, 4'd5, 32'h6000_0200, 4'd3);
    wait_done();
    chk("early_last_drained", exp_rd.size(), 0);

    // write with SLVERR and mismatched BID
    b_id = 4'd7; b_resp = 2'd2;
    push_w(32'h3000_0000, 1, 2);
    push_ax(1, 4'd6, 32'h5000_0200, 4'd1);
    push_dn(2'd2, 3'b001);
    send_cmd(1, 4'd6, 32'h5000_0200, 4'd1);
    wait_done();
    b_resp = 2'd0;

    // write whose B response never comes
    b_en = 0; b_id = 4'd3;
    push_w(32'h4000_0000, 0, 1);
    push_ax(1, 4'd3, 32'h5000_0300, 4'd0);
    push_dn(2'd0, 3'b100);
    send_cmd(1, 4'd3, 32'h5000_0300, 4'd0);
    n = 0;
    while (!BREADY && n < 50) begin
      tick();
      n++;
    end
    chk("b_resp_entry", BREADY, 1);
    n = 0;
    while (!done_valid && n < 40) begin
      if (n == 15) chk("bready_drop_at_expiry", BREADY, 0);
      tick();
      n++;
    end
    chk("timeout_cycles", n, 16);
    chk("bready_in_done", BREADY, 0);
    tick();
    chk("tmo_cmd_ready", cmd_ready, 1);
    chk("tmo_bready_after", BREADY, 0);
    chk("tmo_done_popped", exp_dn.size(), 0);
    b_en = 1;

    // reset during beat 2 of an 8-beat write
    b_id = 4'd4;
    push_w(32'h5500_0000, 7, 2);
    push_ax(1, 4'd4, 32'h5000_0400, 4'd7);
    send_cmd(1, 4'd4, 32'h5000_0400, 4'd7);
    n = w_seen;
    while (w_seen < n + 1 && n < 1000) begin
      tick();
      if (w_seen == 0) n++;
    end
    chk("w_beat2_presented", WVALID, 1);
    ARESET = 1;
    tick();
    ARESET = 0;
    chk("rst_wvalid", WVALID, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_cmd_ready_mid", cmd_ready, 1);
    chk("rst_no_done", done_valid, 0);
    repeat (3) tick();
    chk("rst_w_count", exp_w.size(), 0);

    // read after the abort completes normally
    push_r(4'd3, 32'hD000_0000, 2'd0, 0);
    push_r(4'd3, 32'hD000_0001, 2'd0, 1);
    push_ax(0, 4'd3, 32'h7000_0000, 4'd1);
    push_dn(2'd0, 3'b000);
    send_cmd(0, 4'd3, 32'h7000_0000, 4'd1);
    wait_done();
    repeat (3) tick();
    chk("final_queues",
        exp_aw.size() + exp_ar.size() + exp_rd.size() + exp_w.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/axi_master_initiator.md
Name: axi_master_initiator

Overview:
- Synthesizable single-outstanding AXI initiator (master end) that drives the slave-side channels of any NoC slave port, e.g. S5.
- Takes a command (read or write burst) on a valid/ready port and sequences AW/W/B or AR/R.
- Streams write data in and read data out, checks response ID and RLAST, enforces a response timeout, and reports one status word per transaction.
- AxLOCK/CACHE/PROT/QOS/REGION/USER are not ports of this block; the wrapper ties them to 0.

Parameters:
ID_W, 4, AXI ID width
ADDR_W, 32, address width
DATA_W, 32, data width; STRB width = DATA_W/8
TIMEOUT_CYCLES, 256, idle cycles allowed waiting for B or R beat; 0 disables timeout

Ports:
ACLK  input  1  clock, all logic on posedge
ARESET  input  1  synchronous active-high reset
cmd_valid/cmd_ready  input/output  1/1  command handshake
cmd_write/cmd_id/cmd_addr  input  1/ID_W/ADDR_W  1=write; transaction ID; start address
cmd_len/cmd_size/cmd_burst  input  4/3/2  beats-1 (0-15); AxSIZE; AxBURST
wr_data/wr_strb/wr_valid/wr_ready  in/in/in/out  DATA_W/STRB/1/1  write-data stream
rd_data/rd_last/rd_valid/rd_ready  out/out/out/in  DATA_W/1/1/1  read-data stream
done_valid/done_resp/done_err  output  1/2/3  one-cycle status pulse; worst resp; {timeout, last_err, id_err}
AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID/AWREADY  out x6, in  ID_W/ADDR_W/4/3/2/1/1  write address channel
WDATA/WSTRB/WLAST/WVALID/WREADY  out x4, in  DATA_W/STRB/1/1/1  write data channel
BID/BRESP/BVALID/BREADY  in x3, out  ID_W/2/1/1  write response channel
ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID/ARREADY  out x6, in  ID_W/ADDR_W/4/3/2/1/1  read address channel
RID/RDATA/RRESP/RLAST/RVALID/RREADY  in x5, out  ID_W/DATA_W/2/1/1/1  read data channel

Behaviour:
- States: IDLE, AW_ADDR, W_DATA, B_RESP, AR_ADDR, R_DATA, DONE. Only one transaction is outstanding at a time.
- Reset (ARESET high at posedge): state=IDLE; AWVALID=ARVALID=0; WVALID, BREADY, RREADY, rd_valid, wr_ready and done_valid all 0; cmd_ready=1; Ax payload registers, beat counter, timeout counter, resp/err accumulators all 0.
- Reset mid-operation aborts immediately: VALIDs drop on the next cycle and no done pulse is issued. This is a deliberate AXI violation; the bench resets the slave together with the block.
- cmd_ready = (state==IDLE). On a cmd handshake, payload is registered, beat count=0, accumulators=0.
- Transition from IDLE: to AW_ADDR if cmd_write, else AR_ADDR. AWVALID/ARVALID rise the cycle after the cmd handshake.
- AW_ADDR/AR_ADDR: VALID held high with stable payload until READY. After the handshake, go to W_DATA or R_DATA respectively.
- W_DATA: WVALID=wr_valid, wr_ready=WREADY, WDATA/WSTRB pass through combinationally, WLAST=(beat==len).
  - Each W handshake increments beat.
  - The handshake with WLAST moves to B_RESP.
- B_RESP: BREADY=1. On BVALID: done_resp=BRESP, id_err=(BID!=AWID); go to DONE.
- R_DATA: RREADY=rd_ready, rd_valid=RVALID, rd_data=RDATA, rd_last=RLAST.
  - Each R handshake: beat++, resp_acc=max(resp_acc,RRESP) (numeric), id_err|=(RID!=ARID).
  - The transaction ends on the first beat where RLAST=1 or beat==len. last_err is set if these two conditions disagree. Then go to DONE.
- Timeout:
  - Counter runs in B_RESP, and in R_DATA while RVALID=0. It clears on each B/R handshake and on state entry.
  - Reaching TIMEOUT_CYCLES forces DONE with err[2]=1 and drops BREADY/RREADY that cycle.
  - A VALID arriving in the same cycle as expiry is not accepted.
- DONE: done_valid=1 for exactly one cycle with done_resp and done_err stable; next state IDLE. Minimum cmd-to-cmd spacing is therefore AW + W beats + B + 2 cycles.
- Widths: beat counter is 4 bits; len=15 gives 16 beats with no wrap. AxLEN = cmd_len zero-extended as required.

Test Plan:
- Write: addr=0x5000_0000, len=3, id=2; slave ready always -> AWVALID 1 cycle after cmd, 4 W beats, WLAST only on beat 4; BRESP=0 -> done_resp=0, done_err=0.
- Read: len=7, id=5; slave returns 8 beats RID=5, last beat RLAST -> 8 rd_valid beats, rd_last on 8th, done_err=0; AWREADY held low 5 cycles on a separate write -> AWVALID/AWADDR stable for all 6 cycles.
- Read: len=3; beat 2 RRESP=SLVERR, beat 3 RID=4 instead of 5 -> done_resp=2, done_err=3'b001.
- Read: len=3; slave asserts RLAST on beat 2 -> transaction ends after 2 beats, done_err=3'b010.
- TIMEOUT_CYCLES=16; write with BVALID never asserted -> done_valid exactly 16 cycles after B_RESP entry, done_err=3'b100, BREADY=0 afterwards, cmd_ready=1 next cycle.
- ARESET asserted on W beat 2 of a len=7 write -> WVALID/wr_ready 0 next cycle, no done_valid, cmd_ready=1; a new read cmd afterwards completes normally.
